mem_access_unit: RTL and testbench

- Sequential memory access unit for the multicycle CPU; successor to the combinational load-size extractor.
- Adds byte-offset lane selection, signed and unsigned extension, sub-word stores by read-modify-write, misalignment detection and a ready handshake toward memory.
- Sits between the control unit/ALU address path and the data memory; the control unit issues one access at a time and waits for done.

---
 rtl/mem_access_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle load/store unit with lane selection,
// sign/zero extension, read-modify-write sub-word stores and misalignment trap.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] load_out,
    output logic              done,
    output logic              busy,
    output logic              misaligned
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int SH_W  = OFF_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [1:0]          size_q, size_d;
    logic                sign_ext_q, sign_ext_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   load_out_q, load_out_d;
    logic                done_q, done_d;
    logic                mis_q, mis_d;

    function automatic logic [SH_W-1:0] lane_shift(
        input logic [OFF_W-1:0] off
    );
        return {off, 3'b000};
    endfunction

    function automatic logic [DATA_W-1:0] size_mask(
        input logic [1:0] sz
    );
        logic [DATA_W-1:0] m;
        m = '0;
        case (sz)
            2'b10:   m[7:0]  = '1;
            2'b01:   m[15:0] = '1;
            default: m[31:0] = '1;
        endcase
        return m;
    endfunction

    function automatic logic illegal(
        input logic [1:0]       sz,
        input logic [OFF_W-1:0] off
    );
        return (sz == 2'b11)
            || (sz == 2'b01 && off[0])
            || (sz == 2'b00 && off[1:0] != 2'b00);
    endfunction

    // Lane is shifted down to bit 0, then filled above its width.
    function automatic logic [DATA_W-1:0] extend(
        input logic [DATA_W-1:0] w,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        sz,
        input logic              sx
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] m;
        logic              msb;
        sh = w >> lane_shift(off);
        m  = size_mask(sz);
        case (sz)
            2'b10:   msb = sh[7];
            2'b01:   msb = sh[15];
            default: msb = sh[31];
        endcase
        return (sh & m) | ({DATA_W{sx & msb}} & ~m);
    endfunction

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] w,
        input logic [DATA_W-1:0] sd,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        sz
    );
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] lm;
        m  = size_mask(sz);
        lm = m << lane_shift(off);
        return (w & ~lm) | ((sd & m) << lane_shift(off));
    endfunction

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        sign_ext_d  = sign_ext_q;
        off_d       = off_q;
        sdata_d     = sdata_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_out_d  = load_out_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        done_d      = 1'b0;
        mis_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    size_d     = size;
                    sign_ext_d = sign_ext;
                    off_d      = addr[OFF_W-1:0];
                    sdata_d    = store_data;
                    mem_addr_d = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (illegal(size, addr[OFF_W-1:0])) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else if (is_store && size == 2'b00) begin
                        state_d     = S_WRITE;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = merge('0, store_data,
                                            addr[OFF_W-1:0], 2'b00);
                    end else begin
                        state_d  = S_READ;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    if (is_store_q) begin
                        state_d = S_MERGE;
                    end else begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        load_out_d = extend(mem_rdata, off_q,
                                            size_q, sign_ext_q);
                    end
                end else begin
                    mem_rd_d = 1'b1;
                end
            end
            S_MERGE: begin
                state_d     = S_WRITE;
                mem_wr_d    = 1'b1;
                mem_wdata_d = merge(rdata_q, sdata_q, off_q, size_q);
            end
            S_WRITE: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    mem_wr_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            size_q      <= 2'b00;
            sign_ext_q  <= 1'b0;
            off_q       <= '0;
            sdata_q     <= '0;
            rdata_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_out_q  <= '0;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            sign_ext_q  <= sign_ext_d;
            off_q       <= off_d;
            sdata_q     <= sdata_d;
            rdata_q     <= rdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_out_q  <= load_out_d;
            done_q      <= done_d;
            mis_q       <= mis_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_out   = load_out_q;
    assign done       = done_q;
    assign misaligned = mis_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses against a word-level
// memory model with a stallable ready, checked every cycle.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b1;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] load_out;
    logic        done;
    logic        busy;
    logic        misaligned;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_store   (is_store),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .load_out   (load_out),
        .done       (done),
        .busy       (busy),
        .misaligned (misaligned)
    );

    // Word-addressed memory: 0x10 and 0x20 preloaded.
    logic [31:0] mem [16] = '{32'h0, 32'h0, 32'h0, 32'h0,
                              32'h80F1_7F22, 32'h0, 32'h0, 32'h0,
                              32'h1122_3344, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0};
    assign mem_rdata = mem[mem_addr[5:2]];

    // Stimulus-owned expectations and requests
    int          stall_req = 0;
    int          op_seq = 0;
    int          idle_seq = 0;
    int          rst_seq = 0;
    int          pin_seq = 0;
    int          abort_k = 0;
    logic [31:0] pin_load = 0;
    logic [31:0] pin_mem = 0;
    int          pin_idx = 0;
    logic [31:0] model_load = 0;
    logic [31:0] exp_prev = 0;
    logic [31:0] exp_load = 0;
    logic [31:0] exp_wdata = 0;
    logic [31:0] exp_addr = 0;
    logic        exp_mis = 0;
    int          exp_lat = 0;
    int          exp_rd = 0;
    int          exp_wr = 0;

    // Checker-owned state
    int vectors = 0;
    int miscompares = 0;
    int op_seen = 0;
    int idle_seen = 0;
    int rst_seen = 0;
    int pin_seen = 0;
    bit in_op = 0;
    int kcnt = 0;
    int rd_seen = 0;
    int wr_seen = 0;
    int stall_used = 0;

    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            if (stall_used < stall_req) begin
                mem_ready = 1'b0;
                stall_used++;
            end else begin
                mem_ready = 1'b1;
            end
        end else begin
            mem_ready = 1'b1;
            if (!busy) stall_used = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_wr && mem_ready && !reset)
            mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (op_seq != op_seen) begin
            op_seen = op_seq;
            in_op   = 1;
            kcnt    = 0;
            rd_seen = 0;
            wr_seen = 0;
        end
        if (in_op) begin
            kcnt++;
            if (mem_rd) rd_seen++;
            if (mem_wr) wr_seen++;
            chk("busy", 32'(busy), 32'd1);
            chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'd0);
            chk("mem_addr", mem_addr, exp_addr);
            if (mem_wr) chk("mem_wdata", mem_wdata, exp_wdata);
            if (abort_k != 0 && kcnt == abort_k) begin
                chk("wr_before_reset", 32'(mem_wr), 32'd1);
                in_op = 0;
            end else if (done) begin
                chk("latency", 32'(kcnt), 32'(exp_lat));
                chk("misaligned", 32'(misaligned), 32'(exp_mis));
                chk("load_out", load_out, exp_load);
                chk("rd_cycles", 32'(rd_seen), 32'(exp_rd));
                chk("wr_cycles", 32'(wr_seen), 32'(exp_wr));
                in_op = 0;
            end else begin
                chk("load_hold", load_out, exp_prev);
                chk("mis_low", 32'(misaligned), 32'd0);
                if (kcnt > exp_lat + 3) begin
                    chk("done_latency", 32'(kcnt), 32'(exp_lat));
                    in_op = 0;
                end
            end
        end
        if (idle_seq != idle_seen) begin
            idle_seen = idle_seq;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_rdwr", 32'({mem_rd, mem_wr}), 32'd0);
        end
        if (rst_seq != rst_seen) begin
            rst_seen = rst_seq;
            chk("rst_ctl",
                32'({mem_rd, mem_wr, done, misaligned, busy}), 32'd0);
            chk("rst_load_out", load_out, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
        end
        if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            chk("pin_load_out", load_out, pin_load);
            chk("pin_mem_word", mem[pin_idx], pin_mem);
        end
    end

    task automatic pin(input logic [31:0] lv, input int idx,
                       input logic [31:0] mv);
        pin_load = lv;
        pin_idx  = idx;
        pin_mem  = mv;
        pin_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_op(input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] sd, input int stall,
                         input bit poke);
        logic [31:0] w, sh, v;
        int          off, nb, n;
        logic        mis, rd;
        w   = mem[a[5:2]];
        off = int'(a[1:0]);
        mis = (sz == 2'b11) || (sz == 2'b01 && a[0])
           || (sz == 2'b00 && a[1:0] != 2'b00);
        rd  = !mis && !(st && sz == 2'b00);
        sh  = w >> (8 * off);
        v   = model_load;
        if (!mis && !st) begin
            if (sz == 2'b10) begin
                v = sh & 32'hFF;
                if (sx && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                v = sh & 32'hFFFF;
                if (sx && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
        end
        exp_prev  = model_load;
        exp_load  = v;
        exp_wdata = sd;
        if (sz != 2'b00) begin
            exp_wdata = w;
            nb = (sz == 2'b10) ? 8 : 16;
            for (int i = 0; i < nb; i++)
                exp_wdata[8 * off + i] = sd[i];
        end
        exp_addr  = {a[31:2], 2'b00};
        exp_mis   = mis;
        exp_rd    = rd ? 1 + stall : 0;
        exp_wr    = (st && !mis) ? (rd ? 1 : 1 + stall) : 0;
        exp_lat   = mis ? 1 : (rd && st) ? 4 + stall : 2 + stall;
        stall_req = mis ? 0 : stall;
        is_store   = st;
        size       = sz;
        sign_ext   = sx;
        addr       = a;
        store_data = sd;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_seq++;
        n = 0;
        while ((op_seen != op_seq || in_op) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
            if (poke && n == 1) begin
                addr     = 32'h30;
                size     = 2'b10;
                is_store = 1'b0;
                start    = 1'b1;
            end
            if (poke && n == 2) start = 1'b0;
        end
        model_load = exp_load;
        idle_seq++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_store = 1'b0; size = 2'b00;
        sign_ext = 1'b0; addr = 32'h0; store_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_seq++;
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;

        do_op(0, 2'b10, 1, 32'h13, 32'h0, 0, 0);
        pin(32'hFFFF_FF80, 4, 32'h80F1_7F22);
        do_op(0, 2'b01, 0, 32'h12, 32'h0, 0, 0);
        pin(32'h0000_80F1, 4, 32'h80F1_7F22);
        do_op(0, 2'b01, 1, 32'h12, 32'h0, 0, 0);
        pin(32'hFFFF_80F1, 4, 32'h80F1_7F22);
        do_op(0, 2'b00, 1, 32'h10, 32'h0, 0, 0);
        pin(32'h80F1_7F22, 4, 32'h80F1_7F22);
        do_op(0, 2'b10, 1, 32'h11, 32'h0, 0, 0);
        do_op(0, 2'b01, 1, 32'h10, 32'h0, 0, 0);
        do_op(0, 2'b10, 1, 32'h12, 32'h0, 0, 0);
        pin(32'hFFFF_FFF1, 4, 32'h80F1_7F22);

        do_op(0, 2'b01, 1, 32'h11, 32'h0, 0, 0);
        do_op(0, 2'b00, 0, 32'h12, 32'h0, 0, 0);
        do_op(0, 2'b11, 0, 32'h10, 32'h0, 0, 0);
        do_op(1, 2'b01, 0, 32'h23, 32'h1234, 0, 0);
        pin(32'hFFFF_FFF1, 8, 32'h1122_3344);

        do_op(1, 2'b10, 0, 32'h21, 32'h0000_00AB, 0, 0);
        pin(32'hFFFF_FFF1, 8, 32'h1122_AB44);
        do_op(1, 2'b01, 0, 32'h22, 32'h5555_BEEF, 0, 0);
        pin(32'hFFFF_FFF1, 8, 32'hBEEF_AB44);
        do_op(1, 2'b00, 0, 32'h24, 32'hCAFE_F00D, 0, 0);
        pin(32'hFFFF_FFF1, 9, 32'hCAFE_F00D);
        do_op(1, 2'b00, 0, 32'h28, 32'h0BAD_CAFE, 2, 0);
        pin(32'hFFFF_FFF1, 10, 32'h0BAD_CAFE);

        do_op(0, 2'b00, 0, 32'h20, 32'h0, 3, 1);
        pin(32'hBEEF_AB44, 8, 32'hBEEF_AB44);

        // Abort a sub-word store while it is in WRITE.
        stall_req  = 0;
        abort_k    = 3;
        exp_addr   = 32'h20;
        exp_lat    = 4;
        exp_prev   = model_load;
        exp_mis    = 1'b0;
        exp_wdata  = 32'hBEEF_EE44;
        is_store   = 1'b1;
        size       = 2'b10;
        sign_ext   = 1'b0;
        addr       = 32'h21;
        store_data = 32'h0000_00EE;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_seq++;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        abort_k    = 0;
        model_load = 32'h0;
        rst_seq++;
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle_seq++;
            @(negedge clk);
            #1;
        end
        pin(32'h0, 8, 32'hBEEF_AB44);

        do_op(0, 2'b10, 0, 32'h24, 32'h0, 0, 0);
        pin(32'h0000_000D, 9, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
